// File: rtl/ext_int_source.sv
// External interrupt source: raises `interrupt` after a programmed delay and
// holds it until the CPU's interrupt-response write to ACK_ADDR.
module ext_int_source #(
  parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
  parameter int          CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [31:0] int_ack_addr,
  input  logic [3:0]  int_ack_byteen,
  output logic        interrupt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    PEND = 2'd3
  } state_t;

  state_t           state;
  logic             ctrl_en;
  logic             ctrl_mode;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] count;
  logic [15:0]      ack_cnt;

  logic ctrl_wr;
  logic period_wr;
  logic ack;

  assign ctrl_wr   = WE && (Addr[3:2] == 2'd0);
  assign period_wr = WE && (Addr[3:2] == 2'd1);
  assign ack       = (int_ack_addr == ACK_ADDR) && (int_ack_byteen != 4'b0000);

  // Address bits outside the word-offset field are not decoded.
  logic unused_addr;
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 1'b0;
      period    <= '0;
      count     <= '0;
      ack_cnt   <= 16'd0;
      interrupt <= 1'b0;
    end else begin
      if (period_wr)
        period <= Din[CNT_W-1:0];
      if (state == PEND && ack)
        ack_cnt <= ack_cnt + 16'd1;

      // A CTRL write overrides whatever the state machine would do this edge.
      if (ctrl_wr) begin
        ctrl_en   <= Din[0];
        ctrl_mode <= Din[1];
        interrupt <= 1'b0;
        if (Din[0]) begin
          state <= LOAD;
        end else begin
          state <= IDLE;
          count <= '0;
        end
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            count <= (period == '0) ? CNT_W'(1) : period;
            state <= CNT;
          end
          CNT: begin
            if (count > CNT_W'(1)) begin
              count <= count - CNT_W'(1);
            end else begin
              count     <= '0;
              state     <= PEND;
              interrupt <= 1'b1;
            end
          end
          PEND: begin
            if (ack) begin
              interrupt <= 1'b0;
              if (ctrl_mode && ctrl_en) begin
                state <= LOAD;
              end else begin
                state   <= IDLE;
                ctrl_en <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'd0: Dout = {30'd0, ctrl_mode, ctrl_en};
      2'd1: Dout = 32'(period);
      2'd2: Dout = 32'(count);
      2'd3: Dout = {ack_cnt, 13'd0, state, interrupt};
      default: Dout = 32'd0;
    endcase
  end

endmodule
